stack_cpu_param: RTL and testbench

- Parametrised next-generation stack calculator core.
- Word width and stack depth are generic.
- The stack is owned internally, and a valid/ready handshake on the instruction/operand stream replaces free-running nibble sampling.
- Adds overflow/underflow detection, DUP/SUB/shift ops, depth readback and an output strobe.
- The top-level wrapper maps io_in/io_out onto these ports and drives the seven-segment/output multiplexers from tos and out_word.

---
 rtl/stack_cpu_param.sv | 249 ++++++++++++++++++++++++
 tb/tb_stack_cpu_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_param.sv
// stack_cpu_param: parametrised stack calculator core
// valid/ready instruction stream, internal stack, sticky error flags
module stack_cpu_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DW-1:0]    depth,
  output logic [3:0]       status
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_DUP  = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_UNA  = 4'h7;
  localparam logic [3:0] OP_BINA = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;
  localparam logic [3:0] OP_CLFL = 4'hB;
  localparam logic [3:0] OP_CLRS = 4'hC;

  typedef enum logic [1:0] {
    FETCH,
    OPERAND,
    EXEC,
    EXEC2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] stk [DEPTH];
  logic [3:0]       op;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi;
  logic             carry, err_div, err_stack;

  logic [AW-1:0] ti, ni, pi;
  logic          have1, have2, full;
  logic [3:0]    sel;

  logic [WIDTH-1:0]   una_r, bin_r, psf_r, quo, rem;
  logic               bin_c, bin_cw;
  logic [2*WIDTH-1:0] prod;

  // stack addressing and visible outputs
  always_comb begin
    ti = AW'(depth - DW'(1));
    ni = AW'(depth - DW'(2));
    pi = AW'(depth);
    have1 = depth != '0;
    have2 = depth >= DW'(2);
    full = depth == DW'(DEPTH);
    sel = opnd[3:0];
    tos = have1 ? stk[ti] : '0;
    nos = have2 ? stk[ni] : '0;
    status = {tos == '0, err_stack, err_div, carry};
    in_ready = (state == FETCH) || (state == OPERAND);
  end

  // ALU: unary, binary, push-from selectors, multiply and divide
  always_comb begin
    una_r = tos;
    case (sel)
      4'd0: una_r = ~tos;
      4'd1: una_r = -tos;
      4'd2: una_r = tos + WIDTH'(1);
      4'd3: una_r = tos - WIDTH'(1);
      4'd4: una_r = tos << 1;
      4'd5: una_r = tos >> 1;
      default: una_r = tos;
    endcase
    bin_r = '0;
    bin_c = carry;
    bin_cw = 1'b0;
    case (sel)
      4'd0: begin
        {bin_c, bin_r} = {1'b0, nos} + {1'b0, tos};
        bin_cw = 1'b1;
      end
      4'd1: bin_r = nos & tos;
      4'd2: bin_r = nos | tos;
      4'd3: bin_r = nos ^ tos;
      4'd4: begin
        {bin_c, bin_r} = {1'b0, nos} + {1'b0, tos}
                       + {{WIDTH{1'b0}}, carry};
        bin_cw = 1'b1;
      end
      4'd5: begin
        bin_r = nos - tos;
        bin_c = nos < tos;
        bin_cw = 1'b1;
      end
      default: bin_r = '0;
    endcase
    case (sel)
      4'd0: psf_r = tos;
      4'd1: psf_r = nos;
      4'd2: psf_r = WIDTH'(status);
      4'd3: psf_r = WIDTH'(depth);
      default: psf_r = '0;
    endcase
    prod = {{WIDTH{1'b0}}, nos} * {{WIDTH{1'b0}}, tos};
    quo = (tos == '0) ? '0 : nos / tos;
    rem = (tos == '0) ? '0 : nos % tos;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      FETCH: begin
        if (in_valid) begin
          if (in_data[3:0] == OP_PUSH || in_data[3:0] == OP_PUSF ||
              in_data[3:0] == OP_UNA  || in_data[3:0] == OP_BINA)
            state_n = OPERAND;
          else
            state_n = EXEC;
        end
      end
      OPERAND: if (in_valid) state_n = EXEC;
      EXEC: begin
        if ((op == OP_MULT || op == OP_DIV) && have2) state_n = EXEC2;
        else state_n = FETCH;
      end
      EXEC2: state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  // datapath: latch op/operand, execute, push second result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      depth <= '0;
      op <= '0;
      opnd <= '0;
      hi <= '0;
      out_word <= '0;
      out_valid <= 1'b0;
      carry <= 1'b0;
      err_div <= 1'b0;
      err_stack <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        FETCH: if (in_valid) op <= in_data[3:0];
        OPERAND: if (in_valid) opnd <= in_data;
        EXEC: begin
          case (op)
            OP_PUSH, OP_PUSF: begin
              if (full) err_stack <= 1'b1;
              else begin
                stk[pi] <= (op == OP_PUSH) ? opnd : psf_r;
                depth <= depth + DW'(1);
              end
            end
            OP_POP: begin
              if (!have1) err_stack <= 1'b1;
              else depth <= depth - DW'(1);
            end
            OP_OUT: begin
              if (!have1) err_stack <= 1'b1;
              else begin
                out_word <= tos;
                out_valid <= 1'b1;
              end
            end
            OP_DUP: begin
              if (!have1 || full) err_stack <= 1'b1;
              else begin
                stk[pi] <= tos;
                depth <= depth + DW'(1);
              end
            end
            OP_SWAP: begin
              if (!have2) err_stack <= 1'b1;
              else begin
                stk[ti] <= nos;
                stk[ni] <= tos;
              end
            end
            OP_UNA: begin
              if (!have1) err_stack <= 1'b1;
              else stk[ti] <= una_r;
            end
            OP_BINA: begin
              if (!have2) err_stack <= 1'b1;
              else begin
                stk[ni] <= bin_r;
                depth <= depth - DW'(1);
                if (bin_cw) carry <= bin_c;
              end
            end
            OP_MULT: begin
              if (!have2) err_stack <= 1'b1;
              else begin
                stk[ni] <= prod[WIDTH-1:0];
                hi <= prod[2*WIDTH-1:WIDTH];
                depth <= depth - DW'(1);
              end
            end
            OP_DIV: begin
              if (!have2) err_stack <= 1'b1;
              else begin
                stk[ni] <= quo;
                hi <= rem;
                depth <= depth - DW'(1);
                if (tos == '0) err_div <= 1'b1;
              end
            end
            OP_CLFL: begin
              carry <= 1'b0;
              err_div <= 1'b0;
              err_stack <= 1'b0;
            end
            OP_CLRS: depth <= '0;
            default: ;
          endcase
        end
        EXEC2: begin
          stk[pi] <= hi;
          depth <= depth + DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_param.sv
// tb_stack_cpu_param: directed self-checking bench
// WIDTH=4, DEPTH=4 with hand-computed expectations
module tb_stack_cpu_param;

  localparam int W = 4;
  localparam int D = 4;
  localparam int DW = $clog2(D + 1);

  localparam logic [3:0] PUSH = 4'h1;
  localparam logic [3:0] POP  = 4'h2;
  localparam logic [3:0] OUT  = 4'h3;
  localparam logic [3:0] DUP  = 4'h4;
  localparam logic [3:0] SWAP = 4'h5;
  localparam logic [3:0] PUSF = 4'h6;
  localparam logic [3:0] UNA  = 4'h7;
  localparam logic [3:0] BINA = 4'h8;
  localparam logic [3:0] MULT = 4'h9;
  localparam logic [3:0] DIV  = 4'hA;
  localparam logic [3:0] CLFL = 4'hB;
  localparam logic [3:0] CLRS = 4'hC;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_word;
  logic          out_valid;
  logic [W-1:0]  tos;
  logic [W-1:0]  nos;
  logic [DW-1:0] depth;
  logic [3:0]    status;

  int errors = 0;
  int checks = 0;
  int pulses;

  stack_cpu_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_word(out_word),
    .out_valid(out_valid),
    .tos(tos),
    .nos(nos),
    .depth(depth),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [3:0] w);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("put_ready", int'(in_ready), 1);
    in_data = W'(w);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) chk("idle_ready", int'(in_ready), 1);
  endtask

  task automatic op0(input logic [3:0] o);
    put(o);
    idle();
  endtask

  task automatic op1(input logic [3:0] o, input logic [3:0] v);
    put(o);
    put(v);
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = W'(PUSH);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_tos", int'(tos), 0);
    chk("rst_nos", int'(nos), 0);
    chk("rst_out", int'(out_word), 0);
    chk("rst_ovld", int'(out_valid), 0);
    chk("rst_status", int'(status), 4'b1000);
    in_valid = 1'b0;
    rst_n = 1'b1;

    op1(PUSH, 4'd3);
    op1(PUSH, 4'd5);
    put(BINA);
    put(4'd0);
    @(negedge clk);
    chk("lat_pending", int'(depth), 2);
    @(negedge clk);
    chk("add_depth", int'(depth), 1);
    chk("add_tos", int'(tos), 8);
    chk("add_status", int'(status), 4'b0000);

    op1(PUSH, 4'd9);
    op1(PUSH, 4'd9);
    op1(BINA, 4'd0);
    chk("addc_tos", int'(tos), 2);
    chk("addc_status", int'(status), 4'b0001);
    op1(PUSH, 4'd1);
    op1(BINA, 4'd5);
    chk("sub_tos", int'(tos), 1);
    chk("sub_nos", int'(nos), 8);
    chk("sub_status", int'(status), 4'b0000);
    op0(CLRS);
    chk("clrs_depth", int'(depth), 0);

    op1(PUSH, 4'd7);
    op1(PUSH, 4'd6);
    op0(MULT);
    chk("mul_lo", int'(nos), 4'hA);
    chk("mul_hi", int'(tos), 4'h2);
    chk("mul_depth", int'(depth), 2);

    op0(CLRS);
    op1(PUSH, 4'd7);
    op1(PUSH, 4'd0);
    op0(DIV);
    chk("dz_tos", int'(tos), 0);
    chk("dz_nos", int'(nos), 0);
    chk("dz_depth", int'(depth), 2);
    chk("dz_status", int'(status), 4'b1010);
    op0(CLFL);
    chk("clfl_status", int'(status), 4'b1000);

    op0(CLRS);
    for (int i = 1; i <= 5; i++) op1(PUSH, 4'(i));
    chk("ovf_depth", int'(depth), 4);
    chk("ovf_tos", int'(tos), 4);
    chk("ovf_status", int'(status), 4'b0100);
    for (int i = 0; i < 5; i++) op0(POP);
    chk("unf_depth", int'(depth), 0);
    chk("unf_status", int'(status), 4'b1100);
    op0(CLFL);

    op1(PUSH, 4'hD);
    op1(PUSH, 4'd3);
    op0(DIV);
    chk("div_quo", int'(nos), 4);
    chk("div_rem", int'(tos), 1);
    op0(SWAP);
    chk("swap_tos", int'(tos), 4);
    chk("swap_nos", int'(nos), 1);
    op1(UNA, 4'd1);
    chk("neg_tos", int'(tos), 4'hC);
    op1(UNA, 4'd5);
    chk("shr_tos", int'(tos), 6);
    op0(DUP);
    chk("dup_depth", int'(depth), 3);
    chk("dup_nos", int'(nos), 6);
    op1(PUSF, 4'd3);
    chk("psf_tos", int'(tos), 3);
    chk("psf_depth", int'(depth), 4);
    op1(PUSF, 4'd0);
    chk("psf_full_depth", int'(depth), 4);
    chk("psf_full_status", int'(status), 4'b0100);
    op0(CLFL);
    op0(CLRS);

    put(PUSH);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", int'(in_ready), 1);
      chk("stall_depth", int'(depth), 0);
    end
    put(4'hC);
    idle();
    chk("stall_tos", int'(tos), 4'hC);
    put(OUT);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("out_pulses", pulses, 1);
    chk("out_word", int'(out_word), 4'hC);
    chk("out_depth", int'(depth), 1);

    op0(CLRS);
    op1(PUSH, 4'd7);
    op1(PUSH, 4'd6);
    put(MULT);
    @(posedge clk);
    @(negedge clk);
    chk("ex2_ready", int'(in_ready), 0);
    chk("ex2_depth", int'(depth), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_depth", int'(depth), 0);
    chk("mrst_tos", int'(tos), 0);
    chk("mrst_out", int'(out_word), 0);
    chk("mrst_status", int'(status), 4'b1000);
    chk("mrst_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("mrst_hold", int'(depth), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
